// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, the default
// oversampling ratio and the even-parity helper.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity over up to 32 data bits; callers zero-extend narrower words.
    function automatic logic even_parity(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Signal bundle between a UART transmitter and its host. Handshake: the host pulses
// Tx_WR for one clk with Tx_DATA valid; it is taken only while Tx_EN=1 and Tx_BUSY=0.
interface uart_transmitter_if #(
    parameter int DATA_W = 8
);
    import uart_pkg::*;

    logic              sample_ENABLE;
    logic              Tx_EN;
    logic              Tx_WR;
    logic [DATA_W-1:0] Tx_DATA;
    logic              TxD;
    logic              Tx_BUSY;
    tx_state_e         state_dbg;

    modport master (
        output sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
        input  TxD, Tx_BUSY, state_dbg
    );

    modport slave (
        input  sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
        output TxD, Tx_BUSY, state_dbg
    );

endinterface

// File: rtl/tick_edge_detect.sv
// Registered rising-edge detector: turns the baud controller's sample_ENABLE level
// into a single-clk tick, however long the level stays high.
module tick_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    output logic tick_o
);

    logic sample_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_i;
        end
    end

    assign tick_o = sample_i & ~sample_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to add the parity bit to every frame.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    uart_transmitter_if.slave tx
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e         state_q, state_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [DATA_W-1:0] data_q, data_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              tick, accept, bit_done, last_bit;

    tick_edge_detect u_tick (
        .clk      (clk),
        .reset    (reset),
        .sample_i (tx.sample_ENABLE),
        .tick_o   (tick)
    );

    assign accept      = (state_q == ST_IDLE) && tx.Tx_EN && !busy_q && tx.Tx_WR;
    assign bit_done    = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));
    assign last_bit    = (bit_cnt_q == BW'(DATA_W - 1));
    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_START;
            ST_START: if (bit_done) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_done && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_done) state_d = ST_STOP;
`endif
            ST_STOP:  if (bit_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Each *_d is the value the line/counters take on the next edge, so TxD leaves a flop.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                data_d     = tx.Tx_DATA;
                txd_d      = 1'b0;
                busy_d     = 1'b1;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        end else if (tick) begin
            if (bit_done) begin
                tick_cnt_d = '0;
                case (state_q)
                    ST_START: begin
                        bit_cnt_d = '0;
                        txd_d     = data_q[0];
                    end
                    ST_DATA: begin
                        if (last_bit) begin
                            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                            txd_d = even_parity(32'(data_q));
`else
                            txd_d = 1'b1;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_inc;
                            txd_d     = data_q[bit_cnt_inc];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: txd_d = 1'b1;
`endif
                    ST_STOP: begin
                        txd_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                    default: begin
                        txd_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                endcase
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    assign tx.TxD       = txd_q;
    assign tx.Tx_BUSY   = busy_q;
    assign tx.state_dbg = state_q;

endmodule
